// File: rtl/conv_sequencer_if.sv
// Control/stream handshake bundle between a pixel/weight source and conv_sequencer.
// Master drives requests, pixels and stall; slave returns strobes, window status and coordinates.
interface conv_sequencer_if #(
    parameter int KERN_DIM = 3,
    parameter int WIDTH    = 28,
    parameter int HEIGHT   = 28
);
  localparam int IW = $clog2(KERN_DIM * KERN_DIM);
  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);

  logic          start;
  logic          load_weights;
  logic          w_valid;
  logic          write_weights;
  logic [IW-1:0] w_index;
  logic          px_valid;
  logic          out_stall;
  logic          px_ready;
  logic          three_shift;
  logic          win_valid;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          busy;
  logic          frame_done;

  modport master (
    output start, load_weights, w_valid, px_valid, out_stall,
    input  write_weights, w_index, px_ready, three_shift, win_valid,
           out_row, out_col, busy, frame_done
  );

  modport slave (
    input  start, load_weights, w_valid, px_valid, out_stall,
    output write_weights, w_index, px_ready, three_shift, win_valid,
           out_row, out_col, busy, frame_done
  );
endinterface

// File: rtl/conv_sequencer.sv
// Sequences kernel weight loading and raster pixel streaming for a KxK sliding window.
// win_valid/out_row/out_col lag the accepted pixel by one cycle; out_stall drops px_ready and freezes all counters.
module conv_sequencer #(
    parameter int KERN_DIM = 3,
    parameter int WIDTH    = 28,
    parameter int HEIGHT   = 28,
    parameter int STRIDE   = 1
) (
    input  logic clk,
    input  logic reset,
    conv_sequencer_if.slave bus
);
  localparam int NW = KERN_DIM * KERN_DIM;
  localparam int IW = $clog2(NW);
  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD_W = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [IW-1:0] W_LAST = IW'(NW - 1);
  localparam logic [RW-1:0] R_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] R_K1   = RW'(KERN_DIM - 1);
  localparam logic [CW-1:0] C_K1   = CW'(KERN_DIM - 1);
  localparam logic [PW-1:0] P_LAST = PW'(STRIDE - 1);

  logic [1:0]    state;
  logic [IW-1:0] w_idx;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [PW-1:0] row_ph;
  logic [PW-1:0] col_ph;
  logic          weights_loaded;
  logic          win_valid_q;
  logic [RW-1:0] out_row_q;
  logic [CW-1:0] out_col_q;

  logic accept;
  logic wr;
  logic hit;

  assign accept = (state == STREAM) && bus.px_valid && !bus.out_stall;
  assign wr     = (state == LOAD_W) && bus.w_valid;
  // Phase counters hold (coord - KERN_DIM + 1) mod STRIDE once the coordinate reaches the kernel edge.
  assign hit    = (row >= R_K1) && (col >= C_K1) && (row_ph == '0) && (col_ph == '0);

  assign bus.write_weights = wr;
  assign bus.w_index       = w_idx;
  assign bus.px_ready      = (state == STREAM) && !bus.out_stall;
  assign bus.three_shift   = accept;
  assign bus.win_valid     = win_valid_q;
  assign bus.out_row       = out_row_q;
  assign bus.out_col       = out_col_q;
  assign bus.busy          = (state != IDLE);
  assign bus.frame_done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      w_idx          <= '0;
      row            <= '0;
      col            <= '0;
      row_ph         <= '0;
      col_ph         <= '0;
      weights_loaded <= 1'b0;
      win_valid_q    <= 1'b0;
      out_row_q      <= '0;
      out_col_q      <= '0;
    end else begin
      win_valid_q <= accept && hit;
      if (accept && hit) begin
        out_row_q <= row - R_K1;
        out_col_q <= col - C_K1;
      end
      case (state)
        IDLE: begin
          if (bus.start)
            state <= (bus.load_weights || !weights_loaded) ? LOAD_W : STREAM;
        end
        LOAD_W: begin
          if (wr) begin
            if (w_idx == W_LAST) begin
              w_idx          <= '0;
              weights_loaded <= 1'b1;
              state          <= STREAM;
            end else begin
              w_idx <= w_idx + 1'b1;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            if (col == C_LAST) begin
              col    <= '0;
              col_ph <= '0;
              if (row == R_LAST) begin
                row    <= '0;
                row_ph <= '0;
                state  <= DONE;
              end else begin
                row    <= row + 1'b1;
                row_ph <= (row < R_K1 || row_ph == P_LAST) ? '0 : row_ph + 1'b1;
              end
            end else begin
              col    <= col + 1'b1;
              col_ph <= (col < C_K1 || col_ph == P_LAST) ? '0 : col_ph + 1'b1;
            end
          end
        end
        DONE: begin
          row    <= '0;
          col    <= '0;
          row_ph <= '0;
          col_ph <= '0;
          w_idx  <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: stride-1 and stride-2 instances share stimulus; a scoreboard
// queues expected window coordinates per accepted pixel and retires them on win_valid.
module tb_conv_sequencer;
  localparam int K  = 3;
  localparam int W  = 28;
  localparam int H  = 28;
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);

  logic clk = 1'b0;
  logic reset;
  logic start, load_weights, w_valid, px_valid, out_stall;

  always #5 clk = ~clk;

  conv_sequencer_if #(.KERN_DIM(K), .WIDTH(W), .HEIGHT(H)) b1 ();
  conv_sequencer_if #(.KERN_DIM(K), .WIDTH(W), .HEIGHT(H)) b2 ();

  assign b1.start = start;  assign b1.load_weights = load_weights;  assign b1.w_valid = w_valid;
  assign b1.px_valid = px_valid;  assign b1.out_stall = out_stall;
  assign b2.start = start;  assign b2.load_weights = load_weights;  assign b2.w_valid = w_valid;
  assign b2.px_valid = px_valid;  assign b2.out_stall = out_stall;

  conv_sequencer #(.KERN_DIM(K), .WIDTH(W), .HEIGHT(H), .STRIDE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave));
  conv_sequencer #(.KERN_DIM(K), .WIDTH(W), .HEIGHT(H), .STRIDE(2)) dut2 (
    .clk(clk), .reset(reset), .bus(b2.slave));

  int checks = 0;
  int failures = 0;
  int n_shift, n_win1, n_win2, n_wr, first_win, done_at;
  int m_row = 0;
  int m_col = 0;
  logic [RW+CW-1:0] q1[$];
  logic [RW+CW-1:0] q2[$];
  logic [RW+CW-1:0] exp_rc;

  // Scoreboard monitor: retire last cycle's expectation first, then queue this cycle's.
  always @(negedge clk) begin
    if (reset) begin
      m_row = 0;
      m_col = 0;
      q1.delete();
      q2.delete();
    end else begin
      if (b1.win_valid) begin
        n_win1++;
        if (first_win < 0) first_win = n_shift;
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL win_s1_spurious got row=%0d col=%0d expected no window", b1.out_row, b1.out_col);
        end else begin
          exp_rc = q1.pop_front();
          if ({b1.out_row, b1.out_col} !== exp_rc) begin
            failures++;
            $display("FAIL win_s1_coord got row=%0d col=%0d expected row=%0d col=%0d",
                     b1.out_row, b1.out_col, exp_rc[RW+CW-1:CW], exp_rc[CW-1:0]);
          end
        end
      end else if (q1.size() != 0) begin
        checks++;
        failures++;
        $display("FAIL win_s1_missing got win_valid=0 expected 1");
        q1.delete();
      end
      if (b2.win_valid) begin
        n_win2++;
        checks++;
        if (q2.size() == 0) begin
          failures++;
          $display("FAIL win_s2_spurious got row=%0d col=%0d expected no window", b2.out_row, b2.out_col);
        end else begin
          exp_rc = q2.pop_front();
          if ({b2.out_row, b2.out_col} !== exp_rc) begin
            failures++;
            $display("FAIL win_s2_coord got row=%0d col=%0d expected row=%0d col=%0d",
                     b2.out_row, b2.out_col, exp_rc[RW+CW-1:CW], exp_rc[CW-1:0]);
          end
        end
      end else if (q2.size() != 0) begin
        checks++;
        failures++;
        $display("FAIL win_s2_missing got win_valid=0 expected 1");
        q2.delete();
      end
      if (out_stall && b1.px_ready) begin
        checks++;
        failures++;
        $display("FAIL px_ready_under_stall got 1 expected 0");
      end
      if (b1.frame_done && done_at < 0) done_at = n_shift;
      if (b1.write_weights) n_wr++;
      if (b1.three_shift) begin
        n_shift++;
        if (m_row >= K - 1 && m_col >= K - 1) begin
          q1.push_back({RW'(m_row - K + 1), CW'(m_col - K + 1)});
          if ((m_row - K + 1) % 2 == 0 && (m_col - K + 1) % 2 == 0)
            q2.push_back({RW'(m_row - K + 1), CW'(m_col - K + 1)});
        end
        m_col++;
        if (m_col == W) begin
          m_col = 0;
          m_row++;
          if (m_row == H) m_row = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_shift = 0; n_win1 = 0; n_win2 = 0; n_wr = 0; first_win = -1; done_at = -1;
  endtask

  // Feeds pixels (continuous or randomly gated/stalled) until frame_done or the budget expires.
  task automatic run_frame(input int budget, input bit rnd, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      cyc();
      px_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_stall = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      start        = (i == 100);
      load_weights = (i == 100);
      smp();
      if (done_at >= 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    cyc();
    px_valid = 1'b0; out_stall = 1'b0; start = 1'b0; load_weights = 1'b0;
  endtask

  task automatic test_reset();
    start = 0; load_weights = 0; w_valid = 0; px_valid = 1; out_stall = 0;
    reset = 1;
    clear_counts();
    cyc(); cyc();
    smp();
    checks++;
    if ({b1.write_weights, b1.px_ready, b1.three_shift, b1.win_valid, b1.out_row, b1.out_col,
         b1.busy, b1.frame_done, b1.w_index} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ww=%b rdy=%b sh=%b wv=%b row=%0d col=%0d busy=%b fd=%b widx=%0d expected all 0",
               b1.write_weights, b1.px_ready, b1.three_shift, b1.win_valid, b1.out_row, b1.out_col,
               b1.busy, b1.frame_done, b1.w_index);
    end
    cyc();
    reset = 0; px_valid = 0;
    smp();
    checks++;
    if (b1.busy !== 1'b0 || b2.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b/%b expected 0/0", b1.busy, b2.busy);
    end
  endtask

  task automatic test_load_weights();
    clear_counts();
    cyc();
    start = 1; load_weights = 1;
    cyc();
    start = 0; load_weights = 0;
    smp();
    checks++;
    if (b1.busy !== 1'b1 || b1.px_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_entry got busy=%b px_ready=%b expected 1 0", b1.busy, b1.px_ready);
    end
    for (int i = 0; i < K * K; i++) begin
      cyc();
      w_valid = 0;
      smp();
      checks++;
      if (b1.write_weights !== 1'b0) begin
        failures++;
        $display("FAIL load_idle_strobe got %b expected 0", b1.write_weights);
      end
      cyc();
      w_valid = 1;
      smp();
      checks++;
      if (b1.write_weights !== 1'b1 || b1.w_index !== 4'(i)) begin
        failures++;
        $display("FAIL load_strobe got ww=%b idx=%0d expected ww=1 idx=%0d", b1.write_weights, b1.w_index, i);
      end
    end
    cyc();
    w_valid = 0;
    smp();
    checks++;
    if (b1.px_ready !== 1'b1 || b1.w_index !== '0 || n_wr != K * K) begin
      failures++;
      $display("FAIL load_to_stream got px_ready=%b idx=%0d writes=%0d expected 1 0 %0d",
               b1.px_ready, b1.w_index, n_wr, K * K);
    end
  endtask

  task automatic test_stream_defaults();
    bit to;
    clear_counts();
    run_frame(3000, 1'b0, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL stream_timeout got no frame_done expected one within 3000 cycles");
    end
    checks++;
    if (first_win != 59 || done_at != W * H || n_shift != W * H) begin
      failures++;
      $display("FAIL stream_timing got first_win_after=%0d done_after=%0d shifts=%0d expected 59 %0d %0d",
               first_win, done_at, n_shift, W * H, W * H);
    end
    checks++;
    if (n_win1 != 676 || n_win2 != 169) begin
      failures++;
      $display("FAIL stream_windows got s1=%0d s2=%0d expected 676 169", n_win1, n_win2);
    end
    smp();
    checks++;
    if (b1.busy !== 1'b0 || b1.frame_done !== 1'b0) begin
      failures++;
      $display("FAIL stream_back_idle got busy=%b frame_done=%b expected 0 0", b1.busy, b1.frame_done);
    end
  endtask

  task automatic test_reload_skip_random();
    bit to;
    clear_counts();
    cyc();
    start = 1; load_weights = 0; w_valid = 1;
    cyc();
    start = 0;
    smp();
    checks++;
    if (b1.px_ready !== 1'b1 || b1.write_weights !== 1'b0) begin
      failures++;
      $display("FAIL skip_load got px_ready=%b ww=%b expected 1 0", b1.px_ready, b1.write_weights);
    end
    run_frame(20000, 1'b1, to);
    w_valid = 0;
    checks++;
    if (to) begin
      failures++;
      $display("FAIL random_timeout got no frame_done expected one within 20000 cycles");
    end
    checks++;
    if (n_shift != W * H || n_win1 != 676 || n_win2 != 169 || n_wr != 0) begin
      failures++;
      $display("FAIL random_counts got shifts=%0d s1=%0d s2=%0d writes=%0d expected %0d 676 169 0",
               n_shift, n_win1, n_win2, n_wr, W * H);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    bool_wait: begin end
    clear_counts();
    cyc();
    start = 1; load_weights = 0;
    cyc();
    start = 0; px_valid = 1;
    to = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      smp();
      if (n_shift >= 300) begin
        to = 1'b0;
        break;
      end
    end
    checks++;
    if (to) begin
      failures++;
      $display("FAIL midframe_timeout got shifts=%0d expected 300", n_shift);
    end
    cyc();
    reset = 1; px_valid = 0;
    cyc();
    reset = 0;
    smp();
    checks++;
    if (b1.busy !== 1'b0) begin
      failures++;
      $display("FAIL midframe_reset got busy=%b expected 0", b1.busy);
    end
    clear_counts();
    cyc();
    start = 1; load_weights = 0;
    cyc();
    start = 0; w_valid = 1;
    smp();
    checks++;
    if (b1.busy !== 1'b1 || b1.write_weights !== 1'b1 || b1.w_index !== '0 || b1.px_ready !== 1'b0) begin
      failures++;
      $display("FAIL reload_after_reset got busy=%b ww=%b idx=%0d rdy=%b expected 1 1 0 0",
               b1.busy, b1.write_weights, b1.w_index, b1.px_ready);
    end
    repeat (K * K) cyc();
    w_valid = 0;
    smp();
    checks++;
    if (b1.px_ready !== 1'b1 || n_wr != K * K) begin
      failures++;
      $display("FAIL reload_done got px_ready=%b writes=%0d expected 1 %0d", b1.px_ready, n_wr, K * K);
    end
    clear_counts();
    run_frame(3000, 1'b0, to);
    checks++;
    if (to || first_win != 59 || done_at != W * H || n_win1 != 676 || n_win2 != 169) begin
      failures++;
      $display("FAIL restart_frame got timeout=%b first=%0d done=%0d s1=%0d s2=%0d expected 0 59 %0d 676 169",
               to, first_win, done_at, n_win1, n_win2, W * H);
    end
  endtask

  initial begin
    test_reset();
    test_load_weights();
    test_stream_defaults();
    test_reload_skip_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
